data_mask_queue_ctrl: RTL and testbench

DATA_MASK_QUEUE_CTRL -- requirements
Module: data_mask_queue_ctrl

---
 rtl/data_mask_pkg.sv | 10 +
 rtl/data_mask_ptr_inc.sv | 12 +
 rtl/data_mask_queue_ctrl.sv | 76 +++++++
 tb/tb_data_mask_queue_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mask_pkg.sv
// Shared defaults and types for the data mask queue controller.
package data_mask_pkg;
  localparam int unsigned DEPTH_DEF    = 40;
  localparam int unsigned WIDTH_DEF    = 16;
  localparam int unsigned AW_DEF       = 6;
  localparam int unsigned AF_LEVEL_DEF = 36;

  typedef logic [WIDTH_DEF-1:0] mask_t;
  typedef logic [AW_DEF-1:0]    ptr_t;
endpackage

// File: rtl/data_mask_ptr_inc.sv
// Pointer increment that wraps DEPTH-1 -> 0, so DEPTH need not be a power of two.
module data_mask_ptr_inc #(
  parameter int unsigned DEPTH = 40,
  parameter int unsigned AW    = 6
) (
  input  logic [AW-1:0] ptr,
  output logic [AW-1:0] ptr_nxt
);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  always_comb ptr_nxt = (ptr == LAST) ? '0 : ptr + AW'(1);
endmodule

// File: rtl/data_mask_queue_ctrl.sv
// Circular-queue controller for an external mask storage array (1W/1R, combinational read).
// Optional feature: define DATA_MASK_BYPASS_EN to pass an enqueue straight through an empty queue.
module data_mask_queue_ctrl
  import data_mask_pkg::*;
#(
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned WIDTH    = WIDTH_DEF,
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned AF_LEVEL = AF_LEVEL_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [WIDTH-1:0] enq_mask,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [WIDTH-1:0] deq_mask,
  output logic [AW-1:0]    W0_addr,
  output logic             W0_en,
  output logic [WIDTH-1:0] W0_data,
  output logic [AW-1:0]    R0_addr,
  output logic             R0_en,
  input  logic [WIDTH-1:0] R0_data,
  output logic [AW-1:0]    count,
  output logic             almost_full
);
  localparam logic [AW-1:0] DEPTH_P = AW'(DEPTH);
  localparam logic [AW-1:0] AF_P    = AW'(AF_LEVEL);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW-1:0] wr_ptr_nxt, rd_ptr_nxt;
  logic          q_nonempty, q_valid, bypass, wr_fire, rd_fire;

  data_mask_ptr_inc #(.DEPTH(DEPTH), .AW(AW)) u_wr_inc (.ptr(wr_ptr), .ptr_nxt(wr_ptr_nxt));
  data_mask_ptr_inc #(.DEPTH(DEPTH), .AW(AW)) u_rd_inc (.ptr(rd_ptr), .ptr_nxt(rd_ptr_nxt));

  always_comb begin
    q_nonempty = (count != '0);
    q_valid    = reset & ~flush & q_nonempty;
    enq_ready  = reset & ~flush & (count < DEPTH_P);
`ifdef DATA_MASK_BYPASS_EN
    bypass     = reset & ~flush & ~q_nonempty & enq_valid & deq_ready;
`else
    bypass     = 1'b0;
`endif
    R0_addr     = rd_ptr;
    R0_en       = reset & q_nonempty;
    deq_valid   = q_valid | bypass;
    deq_mask    = bypass ? enq_mask : (R0_en ? R0_data : '0);
    // A bypassed entry is consumed in-flight: no storage write, no pointer movement.
    wr_fire     = enq_valid & enq_ready & ~bypass;
    rd_fire     = q_valid & deq_ready;
    W0_en       = wr_fire;
    W0_addr     = wr_ptr;
    W0_data     = enq_mask;
    almost_full = reset & (count >= AF_P);
  end

  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr_nxt;
      if (rd_fire) rd_ptr <= rd_ptr_nxt;
      case ({wr_fire, rd_fire})
        2'b10:   count <= count + AW'(1);
        2'b01:   count <= count - AW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mask_queue_ctrl.sv
// Directed self-checking bench for data_mask_queue_ctrl with a behavioural storage array.
module tb_data_mask_queue_ctrl;
  localparam int unsigned DEPTH = 40;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned AW    = 6;

  logic             clock = 1'b0;
  logic             reset, flush, enq_valid, deq_ready;
  logic             enq_ready, deq_valid, W0_en, R0_en, almost_full;
  logic [WIDTH-1:0] enq_mask, deq_mask, W0_data, R0_data;
  logic [AW-1:0]    W0_addr, R0_addr, count;
  logic [WIDTH-1:0] mem [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  always @(posedge clock) if (W0_en) mem[W0_addr] <= W0_data;
  assign R0_data = mem[R0_addr];

  data_mask_queue_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW), .AF_LEVEL(36)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_mask(enq_mask),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_mask(deq_mask),
    .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data),
    .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(R0_data),
    .count(count), .almost_full(almost_full)
  );

  // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; enq_valid = 1'b1; deq_ready = 1'b1; enq_mask = 16'h5555;
    #1;
    checks++;
    if ({enq_ready, deq_valid, W0_en, R0_en, almost_full} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00000", {enq_ready, deq_valid, W0_en, R0_en, almost_full});
    end
    checks++;
    if (deq_mask !== 16'h0) begin errors++; $display("FAIL reset_deq_mask got %h want 0000", deq_mask); end
    tick();
    tick();
    reset = 1'b1; enq_valid = 1'b0; deq_ready = 1'b0;
    #1;
    checks++;
    if (count !== 6'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++;
    if (W0_addr !== 6'd0 || R0_addr !== 6'd0) begin
      errors++; $display("FAIL reset_ptrs got w=%0d r=%0d want 0/0", W0_addr, R0_addr);
    end
    checks++;
    if (enq_ready !== 1'b1 || deq_valid !== 1'b0) begin
      errors++; $display("FAIL reset_idle got rdy=%b vld=%b want 1/0", enq_ready, deq_valid);
    end
  endtask

  task automatic test_basic_order();
    enq_valid = 1'b1; enq_mask = 16'hA5A5; deq_ready = 1'b0;
    #1;
    checks++;
    if (W0_en !== 1'b1 || W0_addr !== 6'd0) begin
      errors++; $display("FAIL basic_wr0 got en=%b addr=%0d want 1/0", W0_en, W0_addr);
    end
    tick();
    checks++;
    if (count !== 6'd1 || deq_valid !== 1'b1 || deq_mask !== 16'hA5A5) begin
      errors++; $display("FAIL basic_lat got cnt=%0d vld=%b mask=%h want 1/1/a5a5", count, deq_valid, deq_mask);
    end
    enq_mask = 16'h0F0F;
    #1;
    checks++;
    if (W0_addr !== 6'd1) begin errors++; $display("FAIL basic_wr1 got addr=%0d want 1", W0_addr); end
    tick();
    enq_valid = 1'b0; deq_ready = 1'b1;
    #1;
    checks++;
    if (count !== 6'd2 || deq_mask !== 16'hA5A5) begin
      errors++; $display("FAIL basic_deq0 got cnt=%0d mask=%h want 2/a5a5", count, deq_mask);
    end
    tick();
    checks++;
    if (count !== 6'd1 || deq_mask !== 16'h0F0F) begin
      errors++; $display("FAIL basic_deq1 got cnt=%0d mask=%h want 1/0f0f", count, deq_mask);
    end
    tick();
    deq_ready = 1'b0;
    #1;
    checks++;
    if (count !== 6'd0 || deq_valid !== 1'b0 || deq_mask !== 16'h0 || R0_en !== 1'b0) begin
      errors++; $display("FAIL basic_empty got cnt=%0d vld=%b mask=%h r0en=%b want 0/0/0000/0",
                         count, deq_valid, deq_mask, R0_en);
    end
  endtask

  task automatic test_fill_and_full();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 40; i++) begin
      enq_valid = 1'b1; deq_ready = 1'b0; enq_mask = 16'(16'h0100 + i);
      #1;
      checks++;
      if (enq_ready !== 1'b1 || almost_full !== (i >= 36) || count !== 6'(i)) begin
        errors++; $display("FAIL fill_%0d got rdy=%b af=%b cnt=%0d want 1/%b/%0d",
                           i, enq_ready, almost_full, count, (i >= 36), i);
      end
      tick();
    end
    enq_mask = 16'hDEAD;
    #1;
    checks++;
    if (count !== 6'd40 || enq_ready !== 1'b0 || almost_full !== 1'b1 || W0_en !== 1'b0) begin
      errors++; $display("FAIL full_state got cnt=%0d rdy=%b af=%b w0en=%b want 40/0/1/0",
                         count, enq_ready, almost_full, W0_en);
    end
    tick();
    checks++;
    if (count !== 6'd40) begin errors++; $display("FAIL full_hold got cnt=%0d want 40", count); end
    deq_ready = 1'b1;
    #1;
    checks++;
    if (W0_en !== 1'b0 || deq_valid !== 1'b1 || deq_mask !== 16'h0100) begin
      errors++; $display("FAIL full_both got w0en=%b vld=%b mask=%h want 0/1/0100", W0_en, deq_valid, deq_mask);
    end
    tick();
    enq_valid = 1'b0;
    #1;
    checks++;
    if (count !== 6'd39) begin errors++; $display("FAIL full_both_cnt got %0d want 39", count); end
    for (int i = 1; i < 40; i++) begin
      checks++;
      if (deq_mask !== 16'(16'h0100 + i)) begin
        errors++; $display("FAIL drain_%0d got %h want %h", i, deq_mask, 16'(16'h0100 + i));
      end
      tick();
    end
    deq_ready = 1'b0;
    #1;
    checks++;
    if (count !== 6'd0 || R0_addr !== 6'd0 || W0_addr !== 6'd0) begin
      errors++; $display("FAIL drain_end got cnt=%0d r=%0d w=%0d want 0/0/0", count, R0_addr, W0_addr);
    end
  endtask

  task automatic test_back_to_back();
    enq_valid = 1'b1; deq_ready = 1'b0; enq_mask = 16'h2000;
    tick();
    deq_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      enq_mask = 16'(16'h2000 + k + 1);
      #1;
      checks++;
      if (deq_mask !== 16'(16'h2000 + k) || count !== 6'd1 ||
          R0_addr !== 6'(k % 40) || W0_addr !== 6'((k + 1) % 40)) begin
        errors++; $display("FAIL stream_%0d got mask=%h cnt=%0d r=%0d w=%0d want %h/1/%0d/%0d",
                           k, deq_mask, count, R0_addr, W0_addr, 16'(16'h2000 + k), k % 40, (k + 1) % 40);
      end
      tick();
    end
    enq_valid = 1'b0;
    #1;
    checks++;
    if (deq_mask !== 16'h2064) begin errors++; $display("FAIL stream_last got %h want 2064", deq_mask); end
    tick();
    deq_ready = 1'b0;
    #1;
    checks++;
    if (count !== 6'd0) begin errors++; $display("FAIL stream_end got cnt=%0d want 0", count); end
  endtask

  task automatic test_flush();
    enq_valid = 1'b1; deq_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      enq_mask = 16'(16'h3000 + i);
      tick();
    end
    flush = 1'b1; enq_mask = 16'hFFFF;
    #1;
    checks++;
    if (count !== 6'd10 || W0_en !== 1'b0 || enq_ready !== 1'b0 || deq_valid !== 1'b0) begin
      errors++; $display("FAIL flush_cycle got cnt=%0d w0en=%b rdy=%b vld=%b want 10/0/0/0",
                         count, W0_en, enq_ready, deq_valid);
    end
    tick();
    flush = 1'b0; enq_valid = 1'b0;
    #1;
    checks++;
    if (count !== 6'd0 || deq_valid !== 1'b0 || W0_addr !== 6'd0 || R0_addr !== 6'd0) begin
      errors++; $display("FAIL flush_after got cnt=%0d vld=%b w=%0d r=%0d want 0/0/0/0",
                         count, deq_valid, W0_addr, R0_addr);
    end
  endtask

  task automatic test_reset_mid();
    enq_valid = 1'b1; deq_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      enq_mask = 16'(16'h4000 + i);
      tick();
    end
    reset = 1'b0; enq_mask = 16'hEEEE;
    #1;
    checks++;
    if (count !== 6'd5 || W0_en !== 1'b0 || deq_mask !== 16'h0) begin
      errors++; $display("FAIL rstmid_cycle got cnt=%0d w0en=%b mask=%h want 5/0/0000", count, W0_en, deq_mask);
    end
    tick();
    reset = 1'b1; enq_mask = 16'h1234;
    #1;
    checks++;
    if (count !== 6'd0 || W0_addr !== 6'd0 || W0_en !== 1'b1) begin
      errors++; $display("FAIL rstmid_after got cnt=%0d w=%0d w0en=%b want 0/0/1", count, W0_addr, W0_en);
    end
    tick();
    enq_valid = 1'b0;
    #1;
    checks++;
    if (deq_mask !== 16'h1234 || R0_addr !== 6'd0 || deq_valid !== 1'b1) begin
      errors++; $display("FAIL rstmid_deq got mask=%h r=%0d vld=%b want 1234/0/1", deq_mask, R0_addr, deq_valid);
    end
    deq_ready = 1'b1;
    tick();
    deq_ready = 1'b0;
  endtask

  task automatic test_empty_enq_deq();
    enq_valid = 1'b1; deq_ready = 1'b1; enq_mask = 16'hBEEF;
    #1;
`ifdef DATA_MASK_BYPASS_EN
    checks++;
    if (deq_valid !== 1'b1 || deq_mask !== 16'hBEEF || W0_en !== 1'b0) begin
      errors++; $display("FAIL bypass got vld=%b mask=%h w0en=%b want 1/beef/0", deq_valid, deq_mask, W0_en);
    end
    tick();
    enq_valid = 1'b0; deq_ready = 1'b0;
    #1;
    checks++;
    if (count !== 6'd0 || W0_addr !== 6'd1 || R0_addr !== 6'd1) begin
      errors++; $display("FAIL bypass_after got cnt=%0d w=%0d r=%0d want 0/1/1", count, W0_addr, R0_addr);
    end
`else
    checks++;
    if (deq_valid !== 1'b0 || deq_mask !== 16'h0 || W0_en !== 1'b1) begin
      errors++; $display("FAIL nobypass got vld=%b mask=%h w0en=%b want 0/0000/1", deq_valid, deq_mask, W0_en);
    end
    tick();
    enq_valid = 1'b0;
    #1;
    checks++;
    if (count !== 6'd1 || deq_mask !== 16'hBEEF) begin
      errors++; $display("FAIL nobypass_after got cnt=%0d mask=%h want 1/beef", count, deq_mask);
    end
    tick();
    deq_ready = 1'b0;
`endif
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    test_reset();
    test_basic_order();
    test_fill_and_full();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_empty_enq_deq();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
